// File: rtl/dds_pkg.sv
// Shared constants for the quarter-wave DDS phase path: ROM direction,
// output polarity, quadrant encodings and the dither LFSR definition.
package dds_pkg;

  typedef enum logic {
    FORWARD  = 1'b0,
    BACKWARD = 1'b1
  } memdir_e;

  typedef enum logic {
    POL_POS = 1'b0,
    POL_NEG = 1'b1
  } pol_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dds_quarter_fold.sv
// Quarter-wave fold: maps an in-quadrant index and quadrant onto a ROM
// address, read direction and output sign. Purely combinational.
module dds_quarter_fold
  import dds_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [1:0]        i_quad,
  input  logic              i_clamp,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_memdir,
  output logic              o_data_pol
);

  logic [ADDR_W-1:0] w_idx;

  // A dithered index that overflowed saturates rather than wrapping into
  // the next quadrant's start.
  assign w_idx      = i_clamp ? {ADDR_W{1'b1}} : i_idx;
  assign o_addr     = i_quad[0] ? ~w_idx : w_idx;
  assign o_memdir   = i_quad[0] ? BACKWARD : FORWARD;
  assign o_data_pol = i_quad[1] ? POL_NEG : POL_POS;

endmodule

// File: rtl/dds_phase_sequencer.sv
// Phase accumulator plus registered quarter-wave fold for the sine DDS.
// Optional LFSR phase dither is enabled by defining DDS_PHASE_DITHER_EN.
module dds_phase_sequencer
  import dds_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 7
) (
  input  logic              src_clk,
  input  logic              src_rst_n,
  input  logic              enable,
  input  logic [ACC_W-1:0]  fcw,
  input  logic              set_phase,
  input  logic [ACC_W-1:0]  phase_load,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              memdir,
  output logic              data_pol,
  output logic [1:0]        quadrant,
  output logic              valid,
  output logic              wrap
);

  localparam int FRAC_W = ACC_W - 2;           // bits below the quadrant field
  localparam int TR_W   = ACC_W - 2 - ADDR_W;  // truncated LSBs

  logic [ACC_W-1:0]  r_acc;
  logic              r_carry;
  logic [ACC_W:0]    w_sum;
  logic [1:0]        w_quad;
  logic [ADDR_W-1:0] w_idx;
  logic              w_clamp;
  logic              w_unused;

  logic [ADDR_W-1:0] w_addr;
  logic              w_memdir;
  logic              w_pol;

  logic [ADDR_W-1:0] r_addr;
  logic              r_memdir;
  logic              r_pol;
  logic [1:0]        r_quad;
  logic [1:0]        r_vld_pipe;
  logic              r_wrap;

  assign w_sum  = {1'b0, r_acc} + {1'b0, fcw};
  assign w_quad = r_acc[ACC_W-1 -: 2];

  // Stage 0: accumulator. A load never produces a rollover pulse.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (set_phase) begin
      r_acc   <= phase_load;
      r_carry <= 1'b0;
    end else if (enable) begin
      {r_carry, r_acc} <= w_sum;
    end else begin
      r_carry <= 1'b0;
    end
  end

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0]       r_lfsr;
  logic [FRAC_W-1:0] w_dith;
  logic [FRAC_W:0]   w_dsum;

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n)                r_lfsr <= LFSR_SEED;
    else if (enable && !set_phase) r_lfsr <= lfsr_next(r_lfsr);
  end

  always_comb begin
    w_dith = '0;
    for (int i = 0; i < TR_W && i < 16; i++) w_dith[i] = r_lfsr[i];
  end

  // Dither only perturbs the in-quadrant fraction; its carry becomes a clamp.
  assign w_dsum   = {1'b0, r_acc[FRAC_W-1:0]} + {1'b0, w_dith};
  assign w_idx    = w_dsum[FRAC_W-1 -: ADDR_W];
  assign w_clamp  = w_dsum[FRAC_W];
  assign w_unused = ^w_dsum[TR_W-1:0];
`else
  assign w_idx    = r_acc[FRAC_W-1 -: ADDR_W];
  assign w_clamp  = 1'b0;
  assign w_unused = ^r_acc[TR_W-1:0];
`endif

  dds_quarter_fold #(.ADDR_W(ADDR_W)) u_fold (
    .i_idx      (w_idx),
    .i_quad     (w_quad),
    .i_clamp    (w_clamp),
    .o_addr     (w_addr),
    .o_memdir   (w_memdir),
    .o_data_pol (w_pol)
  );

  // Stage 1: output registers, reloaded every cycle.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_addr     <= '0;
      r_memdir   <= FORWARD;
      r_pol      <= POL_POS;
      r_quad     <= Q0;
      r_vld_pipe <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_addr     <= w_addr;
      r_memdir   <= w_memdir;
      r_pol      <= w_pol;
      r_quad     <= w_quad;
      r_vld_pipe <= {r_vld_pipe[0], enable | set_phase};
      r_wrap     <= r_carry;
    end
  end

  assign addr_rd  = r_addr;
  assign memdir   = r_memdir;
  assign data_pol = r_pol;
  assign quadrant = r_quad;
  assign valid    = r_vld_pipe[1];
  assign wrap     = r_wrap;

endmodule

// File: doc/dds_phase_sequencer.md
# dds_phase_sequencer

Parametrised phase-accumulator address generator for the quarter-wave sine DDS. It advances an ACC_W-bit phase accumulator by a frequency control word every enabled cycle. It folds the accumulator into a quadrant plus an ADDR_W-bit quarter-wave ROM address, and produces the memory direction and output polarity that the sample path uses to rebuild the full sine. It replaces the trigger-stepped quadrant FSM in the same place, between the control registers and the quarter-wave ROM and sign stage.

## Interface
- ACC_W, 24: accumulator width; must be ≥ ADDR_W+3.
- ADDR_W, 7: ROM address width; the ROM depth is 2^ADDR_W.
- src_clk  in  1  sole clock.
- src_rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  advance the accumulator this cycle.
- fcw  in  ACC_W  frequency control word, unsigned.
- set_phase  in  1  load the accumulator from phase_load; has priority over enable.
- phase_load  in  ACC_W  value loaded by set_phase.
- addr_rd  out  ADDR_W  quarter-wave ROM read address.
- memdir  out  1  0 = FORWARD (quadrants 0 and 2), 1 = BACKWARD (quadrants 1 and 3).
- data_pol  out  1  0 = POL_POS (quadrants 0 and 1), 1 = POL_NEG (quadrants 2 and 3).
- quadrant  out  2  current quadrant.
- valid  out  1  outputs correspond to an enabled or loaded accumulator update.
- wrap  out  1  single-cycle pulse when the phase rolls over from quadrant 3 to quadrant 0.

## Operation
- Stage 0 is the accumulator register acc.
  - set_phase=1: acc <= phase_load. No carry is generated.
  - else if enable=1: acc <= acc + fcw, modulo 2^ACC_W. The carry-out is captured as carry.
  - else: acc holds and carry = 0.
- Accumulator fields:
  - quadrant field q = acc[ACC_W-1:ACC_W-2].
  - in-quadrant index a = acc[ACC_W-3:ACC_W-2-ADDR_W].
  - truncated bits are the remaining LSBs.
- Fold rule:
  - q even: addr = a.
  - q odd: addr = (2^ADDR_W−1) − a, i.e. ~a.
  - data_pol = q[1].
  - memdir = q[0].
- Stage 1 is the set of output registers, loaded every cycle from stage 0:
  - addr_rd, memdir, data_pol and quadrant come from the fold of the current acc.
  - valid <= registered (enable | set_phase) of the previous cycle.
  - wrap <= registered carry.
- fcw = 0 with enable=1: outputs stay constant and valid stays 1.
- A simultaneous set_phase and enable loads the accumulator; no add is performed.
- fcw ≥ 2^(ACC_W-2) skips quadrants. This is legal and the fold rule still applies.
- Reset asserted mid-operation clears all state immediately. Operation resumes from acc = 0 on the first enabled edge after release.

## Timing
- Reset values:
  - acc = 0.
  - addr_rd = 0, memdir = 0, data_pol = 0, quadrant = 0, valid = 0, wrap = 0.
  - dither LFSR = 16'hACE1.
- Latency from an input sampled at edge N (enable, fcw, set_phase, phase_load) to the outputs: the outputs reflect it after edge N+1, i.e. 2 cycles of latency.
- wrap is aligned with the first quadrant-0 output after the rollover and is high for exactly one cycle per carry.
- One update is accepted per clock; there is no back-pressure.

## Configuration
- DDS_PHASE_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 16'hACE1) advances on every cycle where enable=1 and set_phase=0.
  - Its low (ACC_W−2−ADDR_W) bits are added to acc[ACC_W-3:0] before folding.
  - If that addition carries out, the index clamps to all-ones. Dither never changes the quadrant.
  - The LFSR state is not observable on any port.
- DDS_PHASE_DITHER_EN undefined: plain truncation, and no LFSR logic is present.

## Structure
- Shared package dds_pkg holds:
  - FORWARD/BACKWARD and POL_POS/POL_NEG.
  - Quadrant constants Q0–Q3.
  - LFSR seed and tap constants.
- Sub-module dds_quarter_fold: combinational block that takes the index and quadrant (plus the optional dither sum) and produces addr, memdir and data_pol. It is reused by a future multi-channel variant.

## Test plan
All scenarios use ACC_W=24 and ADDR_W=7, with the dither macro undefined unless stated.
- Reset: pulse src_rst_n low in the middle of a run → all outputs are 0 asynchronously; after release with enable=1 and fcw=32768, the first valid output is addr_rd=1.
- Full period: fcw=32768, enable held → addr_rd follows this sequence, with wrap asserted once per 512 outputs:
  - quadrant 0: 1…127;
  - quadrant 1, memdir=1: 127…0;
  - quadrant 2, data_pol=1: 0…127;
  - quadrant 3: 127…0, then quadrant 0 addr 0 with wrap=1.
- Phase load: set_phase=1 with phase_load=24'h800000 while enable=1 → 2 cycles later quadrant=2, addr_rd=0, data_pol=1, memdir=0, wrap=0.
- Quadrant skip: fcw=24'h400000 → quadrant steps 1, 2, 3, 0 each cycle; addr_rd alternates 127, 0, 127, 0; wrap=1 every 4th cycle.
- Hold: fcw=0 or enable=0 → outputs frozen; valid=1 with fcw=0, valid=0 with enable=0.
- Dither build: fcw=0, phase_load=24'h3FFFFF → addr_rd stays 127 and quadrant stays 0; phase_load=24'h0A4000 → addr_rd only takes values 20 and 21.
